// File: rtl/pipelined_hc_adder.sv
// Han-Carlson prefix adder/subtractor with valid/ready handshake on both sides.
// Latency: PIPE register stages (1 or 2) from input accept to out_valid.
// Backpressure: per-stage bubble collapse; in_ready drops only when every stage is full and out_ready=0.
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   in_valid/in_ready             - operand handshake; in_a, in_b, in_cin, in_sub operands
//   out_valid/out_ready           - result handshake
//   out_sum, out_cout, out_ovf, out_zero - sum, carry (no-borrow for sub), signed overflow, zero flag
module pipelined_hc_adder #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int LOG = $clog2(WIDTH);
    // Prefix levels: 1 = Brent-Kung pairing, 2..LOG = Kogge-Stone on odd bits,
    // LOG+1 = final Brent-Kung fill of even bits. CUT is the last level in front of
    // the mid-pipe register; with a single stage everything is in front.
    localparam int CUT = (PIPE == 2) ? 1 + LOG / 2 : LOG + 1;

    // One prefix level. Returns {G, P}. After all levels G[i] is the carry out of bit i.
    function automatic logic [2*WIDTH-1:0] hc_level(input int lvl,
                                                    input logic [WIDTH-1:0] g,
                                                    input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;
        go = g;
        po = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (lvl == 1) begin
                if (i % 2 == 1) begin
                    go[i] = g[i] | (p[i] & g[i-1]);
                    po[i] = p[i] & p[i-1];
                end
            end else if (lvl <= LOG) begin
                if ((i % 2 == 1) && (i >= (1 << (lvl - 1)))) begin
                    go[i] = g[i] | (p[i] & g[i-(1<<(lvl-1))]);
                    po[i] = p[i] & p[i-(1<<(lvl-1))];
                end
            end else begin
                if ((i % 2 == 0) && (i > 0)) begin
                    go[i] = g[i] | (p[i] & g[i-1]);
                    po[i] = p[i] & p[i-1];
                end
            end
        end
        return {go, po};
    endfunction

    // Front half: operand conditioning plus prefix levels 1..CUT.
    logic [WIDTH-1:0] f_bx, f_pb, f_g, f_p;
    logic             f_c0;

    always_comb begin
        f_bx = in_sub ? ~in_b : in_b;
        f_c0 = in_sub | in_cin;
        f_pb = in_a ^ f_bx;
        f_g  = in_a & f_bx;
        f_p  = f_pb;
        // Fold the carry-in into bit 0 so no prefix node ever needs it again.
        f_g[0] = f_g[0] | (f_pb[0] & f_c0);
        for (int l = 1; l <= CUT; l++) begin
            {f_g, f_p} = hc_level(l, f_g, f_p);
        end
    end

    // Back half inputs: registered mid-pipe state (PIPE=2) or the front half directly.
    logic [WIDTH-1:0] m_g, m_p, m_pb;
    logic             m_c0, m_amsb, m_bmsb;

    logic [WIDTH-1:0] b_g, b_p, b_sum;
    logic             b_cout, b_ovf, b_zero;

    always_comb begin
        b_g = m_g;
        b_p = m_p;
        for (int l = CUT + 1; l <= LOG + 1; l++) begin
            {b_g, b_p} = hc_level(l, b_g, b_p);
        end
        b_sum  = m_pb ^ {b_g[WIDTH-2:0], m_c0};
        b_cout = b_g[WIDTH-1];
        b_ovf  = (m_amsb == m_bmsb) && (b_sum[WIDTH-1] != m_amsb);
        b_zero = (b_sum == '0);
    end

    // Output stage advances when empty or when its result is being taken.
    logic out_adv;
    assign out_adv = !out_valid || out_ready;

    generate
        if (PIPE == 1) begin : g_pipe1
            assign m_g      = f_g;
            assign m_p      = f_p;
            assign m_pb     = f_pb;
            assign m_c0     = f_c0;
            assign m_amsb   = in_a[WIDTH-1];
            assign m_bmsb   = f_bx[WIDTH-1];
            assign in_ready = out_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_zero  <= 1'b0;
                end else if (out_adv) begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_sum  <= b_sum;
                        out_cout <= b_cout;
                        out_ovf  <= b_ovf;
                        out_zero <= b_zero;
                    end
                end
            end
        end else begin : g_pipe2
            logic s1_valid;
            assign in_ready = !s1_valid || out_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid  <= 1'b0;
                    m_g       <= '0;
                    m_p       <= '0;
                    m_pb      <= '0;
                    m_c0      <= 1'b0;
                    m_amsb    <= 1'b0;
                    m_bmsb    <= 1'b0;
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_zero  <= 1'b0;
                end else begin
                    if (in_ready) begin
                        s1_valid <= in_valid;
                        if (in_valid) begin
                            m_g    <= f_g;
                            m_p    <= f_p;
                            m_pb   <= f_pb;
                            m_c0   <= f_c0;
                            m_amsb <= in_a[WIDTH-1];
                            m_bmsb <= f_bx[WIDTH-1];
                        end
                    end
                    if (out_adv) begin
                        out_valid <= s1_valid;
                        if (s1_valid) begin
                            out_sum  <= b_sum;
                            out_cout <= b_cout;
                            out_ovf  <= b_ovf;
                            out_zero <= b_zero;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_hc_adder.sv
// Self-checking bench for pipelined_hc_adder: arithmetic reference model with
// an in-order expectation queue and per-cycle output/handshake checks.
// Stimulus: directed corner vectors, back-to-back, stall, mid-flight reset, random traffic.
module tb_pipelined_hc_adder #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
);
    localparam int RW = WIDTH + 3;   // {cout, sum, ovf, zero}

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    pipelined_hc_adder #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_res(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{cout,sum,ovf,zero}=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: unsigned and signed arithmetic on the operands as numbers.
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
        logic [WIDTH-1:0]        sum;
        logic                    cout;
        logic signed [WIDTH+1:0] sa, sb, st, hi, lo;
        if (sub) begin
            sum  = a - b;
            cout = (a >= b);
        end else begin
            {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
        sa = $signed({{2{a[WIDTH-1]}}, a});
        sb = $signed({{2{b[WIDTH-1]}}, b});
        st = sub ? (sa - sb) : (sa + sb + $signed({{(WIDTH+1){1'b0}}, cin}));
        hi = '0;
        hi[WIDTH-2:0] = '1;
        lo = ~hi;
        return {cout, sum, (st > hi) || (st < lo), sum == '0};
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [63:0] t;
        case ($urandom_range(0, 5))
            0:       t = '1;
            1:       t = '0;
            2:       t = 64'd1 << (WIDTH - 1);
            3:       t = (64'd1 << (WIDTH - 1)) - 64'd1;
            default: t = {$urandom(), $urandom()};
        endcase
        return t[WIDTH-1:0];
    endfunction

    task automatic rand_ops();
        in_a   = rnd_word();
        in_b   = rnd_word();
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
    endtask

    // ---------------- compare process ----------------
    logic [RW-1:0] exp_q[$];
    int            stamp_q[$];
    int            cyc;
    logic          exp_v, exp_rdy, hold_chk;
    logic [RW-1:0] held;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk_bit("rst_vld", out_valid, 1'b0);
            chk_bit("rst_rdy", in_ready, 1'b1);
            chk_res("rst_out", {out_cout, out_sum, out_ovf, out_zero}, '0);
            exp_q.delete();
            stamp_q.delete();
            cyc      = 0;
            hold_chk = 1'b0;
        end else begin
            // Oldest outstanding op is presented PIPE edges after its accept edge.
            exp_v   = (exp_q.size() > 0) && (stamp_q[0] + PIPE - 1 <= cyc);
            exp_rdy = !((exp_q.size() == PIPE) && !out_ready);
            chk_bit("out_valid", out_valid, exp_v);
            chk_bit("in_ready", in_ready, exp_rdy);
            if (hold_chk)
                chk_res("hold", {out_cout, out_sum, out_ovf, out_zero}, held);
            if (out_valid && exp_q.size() > 0)
                chk_res("data", {out_cout, out_sum, out_ovf, out_zero}, exp_q[0]);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
            hold_chk = out_valid && !out_ready;
            held     = {out_cout, out_sum, out_ovf, out_zero};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
                stamp_q.push_back(cyc + 1);
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic [RW-1:0] exp);
        out_ready = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (PIPE - 1) begin @(posedge clk); #1; end
        chk_bit({name, "_vld"}, out_valid, 1'b1);
        chk_res(name, {out_cout, out_sum, out_ovf, out_zero}, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ones, zw, maxp, minn, neg2;
        int  n;
        bit  full_seen;
        ones = '1;
        zw   = '0;
        maxp = {1'b0, {(WIDTH-1){1'b1}}};
        minn = {1'b1, {(WIDTH-1){1'b0}}};
        neg2 = '1;
        neg2[0] = 1'b0;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed corner vectors.
        directed("wrap_zero", ones, WIDTH'(1), 1'b0, 1'b0, {1'b1, zw, 1'b0, 1'b1});
        directed("pos_ovf",   maxp, WIDTH'(1), 1'b0, 1'b0, {1'b0, minn, 1'b1, 1'b0});
        directed("sub_neg",   WIDTH'(5), WIDTH'(7), 1'b0, 1'b1, {1'b0, neg2, 1'b0, 1'b0});
        directed("cin_only",  zw, zw, 1'b1, 1'b0, {1'b0, WIDTH'(1), 1'b0, 1'b0});
        directed("sub_pos",   WIDTH'(7), WIDTH'(5), 1'b1, 1'b1, {1'b1, WIDTH'(2), 1'b0, 1'b0});
        directed("sub_ovf",   minn, WIDTH'(1), 1'b0, 1'b1, {1'b1, maxp, 1'b1, 1'b0});
        directed("all_ones",  ones, ones, 1'b1, 1'b0, {1'b1, ones, 1'b0, 1'b0});

        // Back-to-back: 8 ops, 8 results on consecutive cycles.
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    rand_ops();
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (PIPE - 1) @(posedge clk);
                for (int k = 0; k < 8; k++) begin
                    #1 chk_bit("b2b_valid", out_valid, 1'b1);
                    @(posedge clk);
                end
                #1;
            end
        join
        repeat (3) begin @(posedge clk); #1; end

        // Stall: fill the pipe with out_ready low, hold 5 cycles, then drain.
        out_ready = 1'b0;
        full_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (!in_ready) begin
                full_seen = 1'b1;
                break;
            end
        end
        chk_bit("stall_fill", full_seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            @(posedge clk); #1;
            chk_bit("stall_rdy", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk_bit("drain_done", out_valid, 1'b0);

        // Reset with ops in flight.
        out_ready = 1'b0;
        rand_ops(); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_ops();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_bit("preset_vld", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async_vld", out_valid, 1'b0);
        chk_bit("async_rdy", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk_bit("no_stale", out_valid, 1'b0);
        end

        // Random traffic with random backpressure.
        for (int k = 0; k < 4000; k++) begin
            rand_ops();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk_bit("drain_empty", exp_q.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
